// File: rtl/simple_bus_mem_slave_if.sv
// Multiplexed simple-bus signals seen by the memory-side target.
// Tristate resolution lives outside; the slave only drives split value/enable pairs.
interface simple_bus_mem_slave_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic              read;
    logic [DATA_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic              dv_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              dv_out;
    logic              dv_oe;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;
    logic [15:0]       xfer_count;

    modport master (
        output start, read, addr_in, data_in, dv_in,
        input  data_out, data_oe, dv_out, dv_oe, busy, err, err_code, xfer_count
    );

    modport slave (
        input  start, read, addr_in, data_in, dv_in,
        output data_out, data_oe, dv_out, dv_oe, busy, err, err_code, xfer_count
    );
endinterface

// File: rtl/simple_bus_mem_slave.sv
// Parametrised memory target for the multiplexed simple bus: MSB-first address beats,
// fixed read latency, write timeout, range/protocol error reporting and a transfer counter.
module simple_bus_mem_slave #(
    parameter int DATA_W       = 8,
    parameter int ADDR_BEATS   = 2,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 3,
    parameter int WR_TIMEOUT   = 8
) (
    input logic                   clock,
    input logic                   resetN,
    simple_bus_mem_slave_if.slave bus
);
    localparam int ADDR_W = DATA_W * ADDR_BEATS;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BEAT_W = $clog2(ADDR_BEATS);
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int TMO_W  = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, RD_DRIVE, WR_WAIT} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [LAT_W-1:0]    lat_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                data_oe_q;
    logic                dv_out_q;
    logic                dv_oe_q;
    logic                busy_q;
    logic                err_q;
    logic [1:0]          err_code_q;
    logic [15:0]         xfer_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [MEM_AW-1:0]   memIdx;
    logic [DATA_W-1:0]   rdData;
    logic                inRange;
    logic                wrEn;
    logic                rangeErr;
    logic                tmoErr;
    logic                startErr;
    logic                err_d;
    logic [1:0]          err_code_d;
    logic [15:0]         xfer_d;

    assign inRange  = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
    assign memIdx   = addr_q[MEM_AW-1:0];
    assign rdData   = mem[memIdx];
    assign wrEn     = (state_q == WR_WAIT) && bus.dv_in && inRange;
    assign xfer_d   = xfer_q + 16'd1;

    // Error sources evaluated on the edge that causes them; code priority 01 > 10 > 11.
    assign rangeErr = ((state_q == RD_WAIT) && (lat_q == LAT_W'(1)) && !inRange) ||
                      ((state_q == WR_WAIT) && bus.dv_in && !inRange);
    assign tmoErr   = (state_q == WR_WAIT) && !bus.dv_in && (tmo_q == TMO_W'(WR_TIMEOUT - 1));
    assign startErr = bus.start && (state_q != IDLE);
    assign err_d    = rangeErr || tmoErr || startErr;
    assign err_code_d = rangeErr ? 2'b01 :
                        tmoErr   ? 2'b10 :
                        startErr ? 2'b11 : err_code_q;

    // Storage is deliberately left out of reset so it survives an aborted transaction.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[memIdx] <= bus.data_in;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            tmo_q      <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            dv_out_q   <= 1'b0;
            dv_oe_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            xfer_q     <= '0;
        end else begin
            err_q      <= err_d;
            err_code_q <= err_code_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q[ADDR_W-1 -: DATA_W] <= bus.addr_in;
                        beat_q  <= BEAT_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    addr_q[(ADDR_BEATS - 1 - int'(beat_q)) * DATA_W +: DATA_W] <= bus.addr_in;
                    beat_q <= beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(ADDR_BEATS - 1)) begin
                        beat_q <= '0;
                        if (bus.read) begin
                            lat_q    <= LAT_W'(READ_LATENCY - 1);
                            dv_oe_q  <= 1'b1;
                            dv_out_q <= 1'b0;
                            state_q  <= RD_WAIT;
                        end else begin
                            tmo_q   <= '0;
                            state_q <= WR_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    lat_q <= lat_q - LAT_W'(1);
                    if (lat_q == LAT_W'(1)) begin
                        data_out_q <= inRange ? rdData : '1;
                        data_oe_q  <= 1'b1;
                        dv_out_q   <= 1'b1;
                        state_q    <= RD_DRIVE;
                    end
                end
                RD_DRIVE: begin
                    data_out_q <= '0;
                    data_oe_q  <= 1'b0;
                    dv_out_q   <= 1'b0;
                    dv_oe_q    <= 1'b0;
                    busy_q     <= 1'b0;
                    xfer_q     <= xfer_d;
                    state_q    <= IDLE;
                end
                WR_WAIT: begin
                    if (bus.dv_in) begin
                        busy_q  <= 1'b0;
                        xfer_q  <= xfer_d;
                        state_q <= IDLE;
                    end else if (tmoErr) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_oe    = data_oe_q;
    assign bus.dv_out     = dv_out_q;
    assign bus.dv_oe      = dv_oe_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.xfer_count = xfer_q;
endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Directed bench for simple_bus_mem_slave: a default 8-bit/2-beat instance and a
// 16-bit/3-beat/latency-5 instance, each driven through its own interface.
module tb_simple_bus_mem_slave;
    logic clock;
    logic resetN;
    logic selB;
    int   vectors;
    int   miscompares;
    bit   errSeenA;

    simple_bus_mem_slave_if #(.DATA_W(8))  busA ();
    simple_bus_mem_slave_if #(.DATA_W(16)) busB ();

    simple_bus_mem_slave #(
        .DATA_W(8), .ADDR_BEATS(2), .DEPTH(4096), .READ_LATENCY(3), .WR_TIMEOUT(8)
    ) dutA (
        .clock  (clock),
        .resetN (resetN),
        .bus    (busA)
    );

    simple_bus_mem_slave #(
        .DATA_W(16), .ADDR_BEATS(3), .DEPTH(4096), .READ_LATENCY(5), .WR_TIMEOUT(8)
    ) dutB (
        .clock  (clock),
        .resetN (resetN),
        .bus    (busB)
    );

    logic [15:0] obsData;
    logic        obsDataOe;
    logic        obsDvOut;
    logic        obsDvOe;
    logic        obsBusy;
    logic        obsErr;
    logic [1:0]  obsCode;
    logic [15:0] obsXfer;

    assign obsData   = selB ? busB.data_out   : {8'h00, busA.data_out};
    assign obsDataOe = selB ? busB.data_oe    : busA.data_oe;
    assign obsDvOut  = selB ? busB.dv_out     : busA.dv_out;
    assign obsDvOe   = selB ? busB.dv_oe      : busA.dv_oe;
    assign obsBusy   = selB ? busB.busy       : busA.busy;
    assign obsErr    = selB ? busB.err        : busA.err;
    assign obsCode   = selB ? busB.err_code   : busA.err_code;
    assign obsXfer   = selB ? busB.xfer_count : busA.xfer_count;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (resetN && busA.err) errSeenA = 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] addr,
                                 input logic [15:0] data, input logic dv);
        if (selB) begin
            busB.start = st; busB.read = rd; busB.addr_in = addr;
            busB.data_in = data; busB.dv_in = dv;
        end else begin
            busA.start = st; busA.read = rd; busA.addr_in = addr[7:0];
            busA.data_in = data[7:0]; busA.dv_in = dv;
        end
    endtask

    // Returns in the cycle after the last address-beat edge.
    task automatic busAddr(input logic [47:0] addr, input logic rd);
        int beats;
        int w;
        logic [47:0] sh;
        beats = selB ? 3 : 2;
        w     = selB ? 16 : 8;
        for (int i = 0; i < beats; i++) begin
            sh = addr >> ((beats - 1 - i) * w);
            applyStimulus(i == 0, (i == beats - 1) ? rd : 1'b0, sh[15:0], 16'h0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic busWrite(input logic [47:0] addr, input logic [15:0] data, input int dvDelay);
        busAddr(addr, 1'b0);
        checkOutput("wr no bus drive", {obsDvOe, obsDataOe}, 2'b00);
        for (int j = 1; j < dvDelay; j++) tick();
        applyStimulus(1'b0, 1'b0, 16'h0, data, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic busRead(input logic [47:0] addr, input bit inject, output int lat,
                           output logic [15:0] data, output logic e, output logic [1:0] c,
                           output logic dOe, output logic eMid, output logic [1:0] cMid);
        int cnt;
        busAddr(addr, 1'b1);
        cnt  = 0;
        eMid = 1'b0;
        cMid = 2'b00;
        if (inject) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
            tick();
            cnt  = 1;
            eMid = obsErr;
            cMid = obsCode;
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        end
        while (!(obsDvOe && obsDvOut) && cnt < 40) begin
            tick();
            cnt++;
        end
        lat  = cnt + 1;
        data = obsData;
        e    = obsErr;
        c    = obsCode;
        dOe  = obsDataOe;
        tick();
    endtask

    initial begin
        int          lat;
        int          cnt;
        logic [15:0] rd;
        logic        e;
        logic [1:0]  c;
        logic        dOe;
        logic        eMid;
        logic [1:0]  cMid;

        vectors     = 0;
        miscompares = 0;
        errSeenA    = 1'b0;
        resetN      = 1'b0;
        selB        = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        selB        = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        #12;
        checkOutput("rst busy", obsBusy, 1'b0);
        checkOutput("rst oe", {obsDvOe, obsDataOe, obsDvOut}, 3'b000);
        checkOutput("rst err", {obsErr, obsCode}, 3'b000);
        checkOutput("rst xfer", obsXfer, 16'd0);
        resetN = 1'b1;
        tick();

        // Basic write then read-back with latency measurement.
        busWrite(48'h0406, 16'h00DC, 2);
        checkOutput("t1 busy after wr", obsBusy, 1'b0);
        busRead(48'h0406, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t1 latency", lat, 3);
        checkOutput("t1 data", rd, 16'h00DC);
        checkOutput("t1 data_oe", dOe, 1'b1);
        checkOutput("t1 xfer", obsXfer, 16'd2);
        checkOutput("t1 no err", errSeenA, 1'b0);

        // Boundary addresses.
        busWrite(48'h0FFF, 16'h001A, 1);
        busWrite(48'h0000, 16'h00BE, 3);
        busRead(48'h0FFF, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t2 rd 0FFF", rd, 16'h001A);
        busRead(48'h0000, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t2 rd 0000", rd, 16'h00BE);

        // Out-of-range read and write.
        busRead(48'h1000, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t3 oor data", rd, 16'h00FF);
        checkOutput("t3 oor err", {e, c}, 3'b101);
        busWrite(48'h1000, 16'h0055, 1);
        checkOutput("t3 oor wr err", {obsErr, obsCode}, 3'b101);
        busRead(48'h0000, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t3 mem0 kept", rd, 16'h00BE);
        checkOutput("t3 xfer", obsXfer, 16'd9);

        // Write timeout.
        busWrite(48'h0010, 16'h0077, 1);
        busAddr(48'h0010, 1'b0);
        cnt = 0;
        while (obsBusy && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput("t4 timeout cycles", cnt, 8);
        checkOutput("t4 timeout err", {obsErr, obsCode}, 3'b110);
        checkOutput("t4 xfer", obsXfer, 16'd10);
        busRead(48'h0010, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t4 mem kept", rd, 16'h0077);

        // Start during RD_WAIT, then reset mid write.
        busRead(48'h0406, 1'b1, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t5 start err", {eMid, cMid}, 3'b111);
        checkOutput("t5 latency", lat, 3);
        checkOutput("t5 data", rd, 16'h00DC);
        busAddr(48'h0020, 1'b0);
        tick();
        checkOutput("t5 busy pre-rst", obsBusy, 1'b1);
        checkOutput("t5 xfer pre-rst", obsXfer, 16'd12);
        resetN = 1'b0;
        #1;
        checkOutput("t5 rst busy", obsBusy, 1'b0);
        checkOutput("t5 rst oe", {obsDvOe, obsDataOe}, 2'b00);
        checkOutput("t5 rst xfer", obsXfer, 16'd0);
        #2;
        resetN = 1'b1;
        tick();
        busRead(48'h0406, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t5 post-rst data", rd, 16'h00DC);
        checkOutput("t5 post-rst xfer", obsXfer, 16'd1);

        // Wide instance: 16-bit data, 3 beats, latency 5.
        selB = 1'b1;
        tick();
        busWrite(48'h0000_0000_0406, 16'hDC5A, 2);
        busRead(48'h0000_0000_0406, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t6 latency", lat, 5);
        checkOutput("t6 data", rd, 16'hDC5A);
        checkOutput("t6 xfer", obsXfer, 16'd2);
        busWrite(48'h0000_0000_0FFF, 16'h1A1A, 1);
        busWrite(48'h0000_0000_0000, 16'hBEEF, 2);
        busRead(48'h0000_0000_0FFF, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t6 rd 0FFF", rd, 16'h1A1A);
        busRead(48'h0000_0000_0000, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t6 rd 0000", rd, 16'hBEEF);
        busRead(48'h0000_0000_1000, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t6 oor data", rd, 16'hFFFF);
        checkOutput("t6 oor err", {e, c}, 3'b101);
        busRead(48'h0001_0000_0406, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t6 top beat oor", {rd, e, c}, {16'hFFFF, 3'b101});
        busWrite(48'h0000_0001_0000, 16'h1234, 1);
        checkOutput("t6 oor wr err", {obsErr, obsCode}, 3'b101);
        busRead(48'h0000_0000_0000, 1'b0, lat, rd, e, c, dOe, eMid, cMid);
        checkOutput("t6 mem0 kept", rd, 16'hBEEF);
        checkOutput("t6 xfer", obsXfer, 16'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
